// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first,
// parallel operands in and a parallel WIDTH+1 result out over valid/ready handshakes.
module serial_addsub #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   y
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic fa_sum(input logic x, input logic z, input logic c);
        return x ^ z ^ c;
    endfunction

    function automatic logic fa_maj(input logic x, input logic z, input logic c);
        return (x & z) | (x & c) | (z & c);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH:0]   y_q, y_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             bit_s;
    logic             bit_c;

    // Next-state and datapath: one FA slice consumes the LSBs of the shifters each RUN cycle.
    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        bit_s       = fa_sum(sa_q[0], sb_q[0], carry_q);
        bit_c       = fa_maj(sa_q[0], sb_q[0], carry_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert B here and seed the carry with sub.
                    sa_d       = a;
                    sb_d       = sub ? ~b : b;
                    carry_d    = sub;
                    cnt_d      = '0;
                    a_msb_d    = a[WIDTH-1];
                    b_msb_d    = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            RUN: begin
                sa_d             = {1'b0, sa_q[WIDTH-1:1]};
                sb_d             = {1'b0, sb_q[WIDTH-1:1]};
                carry_d          = bit_c;
                cnt_d            = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                y_d[WIDTH-1:0]   = {bit_s, y_q[WIDTH-1:1]};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Signed MSB is the sum bit of a sign-extended extra slice.
                    y_d[WIDTH]  = SIGNED ? (a_msb_q ^ b_msb_q ^ bit_c) : bit_c;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State register with asynchronous abort of any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor built around one full-adder slice and a carry flop.
- Trades latency for gate count: one FA per operation instead of WIDTH FAs. This is for FHE netlists where every gate costs one bootstrap.
- Takes parallel operands through a valid/ready handshake, processes them LSB-first one bit per cycle, and returns a parallel WIDTH+1 result.
- Arithmetic matches the team's ripple-carry $add/$sub mapping bit for bit.

Parameters:
- WIDTH, 8, operand width in bits (≥2). Result width is fixed at WIDTH+1.
- SIGNED, 0, 1 selects two's-complement operands and a sign-correct MSB; 0 selects unsigned with MSB = final carry.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands and sub are valid
- in_ready  output  1  block can accept operands
- sub  input  1  0 = add (a+b); 1 = subtract (a-b)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  y holds a finished result
- out_ready  input  1  consumer accepts y
- y  output  WIDTH+1  result

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, y = 0, out_valid = 0.
  - in_ready = 1 (decoded from state).
  - Internal a/b shift registers, carry and bit counter = 0.
- States: IDLE, RUN, DONE. Only one operation is in flight; there is no input/output overlap.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready:
    - latch a into sa and (sub ? ~b : b) into sb;
    - carry <= sub; cnt <= 0; latch SIGNED sign-term inputs;
    - go to RUN.
- RUN (in_ready = 0):
  - Each cycle: s = sa[0]^sb[0]^carry; carry <= maj(sa[0], sb[0], carry).
  - sa and sb shift right by 1; s shifts into the result register from the top (y[WIDTH-1] end); cnt++.
  - When cnt == WIDTH-1, the current cycle is the last bit. Form the MSB and go to DONE:
    - SIGNED = 0: y[WIDTH] = carry-out of the last bit, for both add and sub. A sub with no borrow gives MSB 1; a borrow gives 0.
    - SIGNED = 1: y[WIDTH] = a[WIDTH-1] ^ b'[WIDTH-1] ^ carry-out, where b' is the latched, possibly inverted, B.
- Latency: accept edge, then WIDTH RUN cycles; out_valid rises on the WIDTH-th edge after the accept edge (8 for WIDTH = 8).
- DONE:
  - out_valid = 1; y is stable and held until the handshake.
  - On out_ready: out_valid <= 0, go to IDLE. in_ready is 1 in the next cycle (no same-cycle turnaround).
  - Without out_ready, DONE is held indefinitely; y does not change.
- Inputs a, b and sub are sampled only on the accept edge; later changes have no effect.
- in_valid during RUN or DONE is ignored; the source must hold it until in_ready.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted and discarded, and every output returns to its reset value immediately (async, no clock needed).
- Reset deasserted: first accept is possible on the first clk edge after deassertion.
- Wrap-around: no saturation; results are modulo 2^(WIDTH+1) under the rules above.

Test Plan:
- WIDTH=8, SIGNED=0, add 200+100 → out_valid 8 cycles after accept, y = 9'h12C (300).
- WIDTH=8, SIGNED=0, sub 5−7 → y = 9'h0FE (low 0xFE, MSB carry 0 = borrow). Sub 7−5 → y = 9'h102.
- WIDTH=8, SIGNED=1, add 0xFD+0xFB (−3 + −5) → y = 9'h1F8 (−8). Sub 0x7F−0x80 (127 − (−128)) → y = 9'h0FF (255).
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid → y constant, in_ready = 0 throughout. Raising out_ready → out_valid falls next edge and in_ready = 1; a new operand is accepted one cycle later.
- Assert rst mid-RUN (after 3 bits), then resume → out_valid/y cleared asynchronously, in_ready = 1. A following 1+1 add gives y = 9'h002 with normal latency.
- Back-to-back: in_valid held high with changing a/b and out_ready = 1 → each result matches the operands present at its accept edge; in_valid during RUN has no effect.
